// File: rtl/i2c_eeprom_slave_model.sv
// Clocked I2C EEPROM slave responder: synchronised SCL/SDA decode, byte/page writes,
// random/current/sequential reads and write-cycle busy modelling (address NACK polling).
module i2c_eeprom_slave_model #(
  parameter logic [6:0] DEV_ADDR   = 7'b1010000,
  parameter int         ADDR_BYTES = 2,
  parameter int         MEM_AW     = 13,
  parameter int         PAGE_SIZE  = 32,
  parameter int         WR_CYCLES  = 250000
) (
  input  logic              CLK_50M,
  input  logic              RSTn,
  input  logic              SCL,
  input  logic              SDA_in,
  output logic              SDA_oe,
  output logic              busy,
  output logic [MEM_AW-1:0] addr_ptr,
  output logic              bus_active
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DEV       = 4'd1;
  localparam logic [3:0] ST_DEV_ACK   = 4'd2;
  localparam logic [3:0] ST_WADDR     = 4'd3;
  localparam logic [3:0] ST_WADDR_ACK = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK      = 4'd8;
  localparam logic [3:0] ST_WAIT_STOP = 4'd9;

  localparam int              CNT_W   = $clog2(WR_CYCLES + 1);
  localparam logic [MEM_AW-1:0] PG_MASK = MEM_AW'(PAGE_SIZE - 1);
  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

  logic [2:0]        scl_sync_q, sda_sync_q;
  logic [3:0]        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0] addr_ptr_q, addr_ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              bus_active_q, bus_active_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic              wrote_q, wrote_d;
  logic              rw_q, rw_d;
  logic              mack_q, mack_d;
  logic              mem_we;
  logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

  logic scl_rise, scl_fall, start_det, stop_det, rx_state, byte_done;
  logic [MEM_AW-1:0] page_next;
  logic [7:0]        rd_byte;

  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
  assign rx_state  = (state_q == ST_DEV) | (state_q == ST_WADDR) | (state_q == ST_WDATA);
  assign byte_done = scl_fall & (bit_cnt_q == 4'd8);
  assign page_next = (addr_ptr_q & ~PG_MASK) | ((addr_ptr_q + PTR_ONE) & PG_MASK);
  assign rd_byte   = mem_q[addr_ptr_q];

  // Bus synchroniser plus one extra stage for edge detection
  always_ff @(posedge CLK_50M) begin
    scl_sync_q <= {scl_sync_q[1:0], SCL};
    sda_sync_q <= {sda_sync_q[1:0], SDA_in};
  end

  // Protocol FSM next-state logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    addr_hi_d    = addr_hi_q;
    addr_ptr_d   = addr_ptr_q;
    sda_oe_d     = sda_oe_q;
    bus_active_d = bus_active_q;
    busy_d       = busy_q;
    busy_cnt_d   = busy_cnt_q;
    wrote_d      = wrote_q;
    rw_d         = rw_q;
    mack_d       = mack_q;
    mem_we       = 1'b0;

    if (busy_q && (busy_cnt_q != {CNT_W{1'b0}})) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end else begin
      busy_d     = 1'b0;
      busy_cnt_d = {CNT_W{1'b0}};
    end

    if (start_det) begin
      bus_active_d = 1'b1;
      bit_cnt_d    = 4'd0;
      byte_cnt_d   = 2'd0;
      addr_hi_d    = 8'h00;
      wrote_d      = 1'b0;
      state_d      = ST_DEV;
    end else if (stop_det) begin
      sda_oe_d     = 1'b0;
      bus_active_d = 1'b0;
      state_d      = ST_IDLE;
      wrote_d      = 1'b0;
      if (wrote_q) begin
        busy_d     = 1'b1;
        busy_cnt_d = CNT_W'(WR_CYCLES);
      end else begin
        busy_d     = busy_d;
      end
    end else begin
      if (rx_state && scl_rise && (bit_cnt_q < 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_sync_q[1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        shift_d   = shift_q;
      end

      case (state_q)
        ST_DEV: begin
          if (byte_done) begin
            bit_cnt_d = 4'd0;
            if ((shift_q[7:1] == DEV_ADDR) && !busy_q) begin
              state_d  = ST_DEV_ACK;
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = ST_RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_WADDR;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_WADDR: begin
          if (byte_done) begin
            state_d    = ST_WADDR_ACK;
            sda_oe_d   = 1'b1;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            state_d = state_q;
          end
        end
        ST_WADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (byte_cnt_q == 2'(ADDR_BYTES)) begin
              addr_ptr_d = MEM_AW'({addr_hi_q, shift_q});
              state_d    = ST_WDATA;
            end else begin
              addr_hi_d  = shift_q;
              state_d    = ST_WADDR;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            mem_we     = 1'b1;
            wrote_d    = 1'b1;
            sda_oe_d   = 1'b1;
            addr_ptr_d = page_next;
            state_d    = ST_WDATA_ACK;
          end else begin
            state_d = state_q;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA;
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RACK;
          end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else begin
            state_d = state_q;
          end
        end
        // bit_cnt 8 -> 9 marks that the master acknowledge has been sampled
        ST_RACK: begin
          if (scl_rise && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d  = 4'd9;
            addr_ptr_d = addr_ptr_q + PTR_ONE;
            mack_d     = ~sda_sync_q[1];
          end else if (scl_fall && (bit_cnt_q == 4'd9)) begin
            bit_cnt_d = 4'd0;
            if (mack_q) begin
              state_d  = ST_RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge CLK_50M) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      byte_cnt_q   <= 2'd0;
      addr_hi_q    <= 8'h00;
      addr_ptr_q   <= {MEM_AW{1'b0}};
      sda_oe_q     <= 1'b0;
      bus_active_q <= 1'b0;
      busy_q       <= 1'b0;
      busy_cnt_q   <= {CNT_W{1'b0}};
      wrote_q      <= 1'b0;
      rw_q         <= 1'b0;
      mack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_hi_q    <= addr_hi_d;
      addr_ptr_q   <= addr_ptr_d;
      sda_oe_q     <= sda_oe_d;
      bus_active_q <= bus_active_d;
      busy_q       <= busy_d;
      busy_cnt_q   <= busy_cnt_d;
      wrote_q      <= wrote_d;
      rw_q         <= rw_d;
      mack_q       <= mack_d;
    end
  end

  // Memory array; contents survive reset
  always_ff @(posedge CLK_50M) begin
    if (RSTn && mem_we) begin
      mem_q[addr_ptr_q] <= shift_q;
    end
  end

  assign SDA_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign addr_ptr   = addr_ptr_q;
  assign bus_active = bus_active_q;

endmodule

// File: tb/tb_i2c_eeprom_slave_model.sv
// Directed bench for i2c_eeprom_slave_model: a bit-banged I2C master with an
// open-drain wire model and hand-computed expected bytes/flags.
module tb_i2c_eeprom_slave_model;

  localparam int WRC = 2000;
  localparam int Q   = 8;
  localparam logic [3:0] ST_WAIT_STOP = 4'd9;

  logic        clk = 1'b0;
  logic        rstn, scl, sda_m, sda_w;
  logic        sda_oe, busy, bus_active;
  logic [12:0] addr_ptr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #10 clk = ~clk;
  assign sda_w = sda_m & ~sda_oe;

  i2c_eeprom_slave_model #(
    .DEV_ADDR(7'b1010000), .ADDR_BYTES(2), .MEM_AW(13), .PAGE_SIZE(32), .WR_CYCLES(WRC)
  ) dut (
    .CLK_50M(clk), .RSTn(rstn), .SCL(scl), .SDA_in(sda_w),
    .SDA_oe(sda_oe), .busy(busy), .addr_ptr(addr_ptr), .bus_active(bus_active)
  );

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq(Q); scl = 1'b1; wq(2*Q); scl = 1'b0; wq(Q);
    end
    sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); ack = ~sda_w; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe9);
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); d[i] = sda_w; wq(Q); scl = 1'b0; wq(Q);
    end
    sda_m = mack ? 1'b0 : 1'b1; wq(Q); scl = 1'b1; wq(Q); oe9 = sda_oe; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic set_read_addr(input logic [15:0] a, output logic ok);
    logic k0, k1, k2, k3;
    i2c_start(); send_byte(8'hA0, k0); send_byte(a[15:8], k1); send_byte(a[7:0], k2);
    i2c_start(); send_byte(8'hA1, k3);
    ok = k0 & k1 & k2 & k3;
  endtask

  task automatic wait_busy_clear(output int n);
    n = 0;
    while (busy && (n < WRC + 100)) begin wq(1); n++; end
  endtask

  task automatic test_reset();
    rstn = 1'b0; scl = 1'b1; sda_m = 1'b1; wq(5);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b exp 0", sda_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if (addr_ptr !== 13'h0000) begin n_fail++; $display("FAIL reset_ptr: got %h exp 0000", addr_ptr); end
    n_tests++; if (bus_active !== 1'b0) begin n_fail++; $display("FAIL reset_bus: got %b exp 0", bus_active); end
    rstn = 1'b1; wq(5);
  endtask

  task automatic test_byte_write();
    logic [7:0] seq [4] = '{8'hA0, 8'h01, 8'h23, 8'h5A};
    logic ack; int n;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], ack);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bw_ack%0d: got %b exp 1", i, ack); end
    end
    n_tests++; if (bus_active !== 1'b1) begin n_fail++; $display("FAIL bw_bus_active: got %b exp 1", bus_active); end
    i2c_stop(); wq(2);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bw_busy_set: got %b exp 1", busy); end
    n_tests++; if (addr_ptr !== 13'h0124) begin n_fail++; $display("FAIL bw_ptr: got %h exp 0124", addr_ptr); end
    n_tests++; if (bus_active !== 1'b0) begin n_fail++; $display("FAIL bw_bus_idle: got %b exp 0", bus_active); end
    wait_busy_clear(n);
    n_tests++;
    if (busy !== 1'b0 || n < WRC - 20 || n > WRC + 2) begin
      n_fail++; $display("FAIL bw_busy_len: got %0d cycles busy=%b exp about %0d", n, busy, WRC);
    end
  endtask

  task automatic test_random_read();
    logic ok, oe9; logic [7:0] d;
    set_read_addr(16'h0123, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_acks: got %b exp 1", ok); end
    read_byte(1'b0, d, oe9);
    n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rr_data: got %h exp 5a", d); end
    n_tests++; if (oe9 !== 1'b0) begin n_fail++; $display("FAIL rr_oe9: got %b exp 0", oe9); end
    i2c_stop(); wq(2);
    n_tests++; if (bus_active !== 1'b0) begin n_fail++; $display("FAIL rr_bus: got %b exp 0", bus_active); end
    n_tests++; if (addr_ptr !== 13'h0124) begin n_fail++; $display("FAIL rr_ptr: got %h exp 0124", addr_ptr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_nobusy: got %b exp 0", busy); end
  endtask

  task automatic test_page_wrap();
    logic [7:0] seq [7] = '{8'hA0, 8'h00, 8'h1E, 8'h11, 8'h22, 8'h33, 8'h44};
    logic ack, ok, oe9; logic [7:0] d0, d1; int n;
    i2c_start();
    for (int i = 0; i < 7; i++) begin
      send_byte(seq[i], ack);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL pw_ack%0d: got %b exp 1", i, ack); end
    end
    i2c_stop(); wq(2);
    n_tests++; if (addr_ptr !== 13'h0002) begin n_fail++; $display("FAIL pw_ptr: got %h exp 0002", addr_ptr); end
    wait_busy_clear(n);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pw_busy_timeout: got %b after %0d", busy, n); end
    set_read_addr(16'h0000, ok); read_byte(1'b1, d0, oe9); read_byte(1'b0, d1, oe9); i2c_stop();
    n_tests++; if ({ok, d0, d1} !== {1'b1, 8'h33, 8'h44}) begin n_fail++; $display("FAIL pw_low: got %b %h %h exp 1 33 44", ok, d0, d1); end
    set_read_addr(16'h001E, ok); read_byte(1'b1, d0, oe9); read_byte(1'b0, d1, oe9); i2c_stop();
    n_tests++; if ({ok, d0, d1} !== {1'b1, 8'h11, 8'h22}) begin n_fail++; $display("FAIL pw_high: got %b %h %h exp 1 11 22", ok, d0, d1); end
  endtask

  task automatic test_seq_read_wrap();
    logic [7:0] seq [5] = '{8'hA0, 8'h1F, 8'hFE, 8'hAA, 8'hBB};
    logic [7:0] exp_d [3] = '{8'hAA, 8'hBB, 8'h33};
    logic ack, all_ack, ok, oe9; logic [7:0] d; int n;
    all_ack = 1'b1;
    i2c_start();
    for (int i = 0; i < 5; i++) begin send_byte(seq[i], ack); all_ack &= ack; end
    i2c_stop(); wait_busy_clear(n);
    n_tests++; if (all_ack !== 1'b1) begin n_fail++; $display("FAIL sr_wr_acks: got %b exp 1", all_ack); end
    set_read_addr(16'h1FFE, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sr_addr_acks: got %b exp 1", ok); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i < 2, d, oe9);
      n_tests++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL sr_byte%0d: got %h exp %h", i, d, exp_d[i]); end
    end
    i2c_stop(); wq(2);
    n_tests++; if (addr_ptr !== 13'h0001) begin n_fail++; $display("FAIL sr_ptr: got %h exp 0001", addr_ptr); end
  endtask

  task automatic test_busy_poll();
    logic [7:0] seq [4] = '{8'hA0, 8'h02, 8'h00, 8'h77};
    logic ack; int n;
    i2c_start();
    for (int i = 0; i < 4; i++) send_byte(seq[i], ack);
    i2c_stop(); wq(2);
    i2c_start(); send_byte(8'hA0, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL bp_busy_nack: got ack=%b exp 0", ack); end
    i2c_stop();
    wait_busy_clear(n);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_timeout: got %b after %0d", busy, n); end
    i2c_start(); send_byte(8'hA0, ack);
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bp_ready_ack: got ack=%b exp 1", ack); end
    i2c_stop(); wq(2);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_write_busy: got %b exp 0", busy); end
    i2c_start(); send_byte(8'hA2, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL bp_wrong_addr: got ack=%b exp 0", ack); end
    n_tests++; if (dut.state_q !== ST_WAIT_STOP) begin n_fail++; $display("FAIL bp_wait_stop: got state %0d exp %0d", dut.state_q, ST_WAIT_STOP); end
    send_byte(8'h00, ack);
    n_tests++; if ({ack, bus_active} !== 2'b01) begin n_fail++; $display("FAIL bp_ignored: got ack=%b bus=%b exp 0 1", ack, bus_active); end
    i2c_stop(); wq(2);
  endtask

  task automatic test_reset_mid_read();
    logic ok, oe9; logic [7:0] d;
    set_read_addr(16'h0123, ok);
    n_tests++; if ({ok, sda_oe} !== 2'b11) begin n_fail++; $display("FAIL mr_drive0: got ok=%b oe=%b exp 1 1", ok, sda_oe); end
    rstn = 1'b0; wq(1);
    n_tests++;
    if ({sda_oe, busy, bus_active, addr_ptr} !== {3'b000, 13'h0000}) begin
      n_fail++; $display("FAIL mr_reset_vals: got oe=%b busy=%b bus=%b ptr=%h exp 0 0 0 0000", sda_oe, busy, bus_active, addr_ptr);
    end
    rstn = 1'b1; wq(4);
    i2c_stop();
    set_read_addr(16'h0123, ok); read_byte(1'b0, d, oe9); i2c_stop();
    n_tests++; if ({ok, d} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL mr_mem_kept: got %b %h exp 1 5a", ok, d); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; scl = 1'b1; sda_m = 1'b1;
    test_reset();
    test_byte_write();
    test_random_read();
    test_page_wrap();
    test_seq_read_wrap();
    test_busy_poll();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
